// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle: stage register/hazard info in,
// pipeline-register enables, flushes, forwarding selects and mul/div sequencing out.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic             memread_e, muldiv_e, pcsrc_e;
  logic             regwrite_m, regwrite_w;
  logic             dmem_req_m, dmem_ready;
  logic             en_f, en_d, en_e, en_m, en_w;
  logic             flush_d, flush_e, flush_m;
  logic [1:0]       fwd_a_e, fwd_b_e;
  logic             muldiv_start, muldiv_done;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  modport master (
    output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
           memread_e, muldiv_e, pcsrc_e, regwrite_m, regwrite_w,
           dmem_req_m, dmem_ready,
    input  en_f, en_d, en_e, en_m, en_w, flush_d, flush_e, flush_m,
           fwd_a_e, fwd_b_e, muldiv_start, muldiv_done, stall_cnt, flush_cnt
  );

  modport slave (
    input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
           memread_e, muldiv_e, pcsrc_e, regwrite_m, regwrite_w,
           dmem_req_m, dmem_ready,
    output en_f, en_d, en_e, en_m, en_w, flush_d, flush_e, flush_m,
           fwd_a_e, fwd_b_e, muldiv_start, muldiv_done, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: forwarding, load-use stall, branch flush,
// data-memory freeze and fixed-latency mul/div sequencing, plus perf counters.
module hazard_ctrl #(
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 32
) (
  input  logic           clk,
  input  logic           reset_n,
  hazard_ctrl_if.slave   hz
);
  localparam int CW = $clog2(MULDIV_LAT) + 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  logic w_freeze, w_load_use;
  logic w_en_f, w_en_d, w_en_e, w_en_m, w_en_w;
  logic w_flush_d, w_flush_e, w_flush_m;
  logic w_start, w_done;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic wr_m, input logic [4:0] rd_m,
                                         input logic wr_w, input logic [4:0] rd_w);
    if (wr_m && rd_m != 5'd0 && rd_m == rs)      return 2'b10;
    else if (wr_w && rd_w != 5'd0 && rd_w == rs) return 2'b01;
    else                                         return 2'b00;
  endfunction

  assign w_freeze   = hz.dmem_req_m & ~hz.dmem_ready;
  assign w_load_use = hz.memread_e && hz.rd_e != 5'd0 &&
                      (hz.rd_e == hz.rs1_d || hz.rd_e == hz.rs2_d);

  assign hz.fwd_a_e = fwd_sel(hz.rs1_e, hz.regwrite_m, hz.rd_m, hz.regwrite_w, hz.rd_w);
  assign hz.fwd_b_e = fwd_sel(hz.rs2_e, hz.regwrite_m, hz.rd_m, hz.regwrite_w, hz.rd_w);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // BUSY keeps counting through freezes; only IDLE and DONE hold while frozen.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: if (!w_freeze && hz.muldiv_e) begin
        w_state_nxt = S_BUSY;
        w_cnt_nxt   = CW'(MULDIV_LAT - 1);
      end
      S_BUSY: if (r_cnt == '0) w_state_nxt = S_DONE;
              else             w_cnt_nxt   = r_cnt - 1'b1;
      S_DONE: if (!w_freeze) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    {w_en_f, w_en_d, w_en_e, w_en_m, w_en_w} = 5'b11111;
    {w_flush_d, w_flush_e, w_flush_m}        = 3'b000;
    w_start = 1'b0;
    w_done  = 1'b0;
    if (w_freeze) begin
      {w_en_f, w_en_d, w_en_e, w_en_m, w_en_w} = 5'b00000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (hz.muldiv_e) begin
            w_start = 1'b1;
            {w_en_f, w_en_d, w_en_e} = 3'b000;
            w_flush_m = 1'b1;
          end else if (hz.pcsrc_e) begin
            // the load-use victim is squashed by the branch anyway
            w_flush_d = 1'b1;
            w_flush_e = 1'b1;
          end else if (w_load_use) begin
            {w_en_f, w_en_d} = 2'b00;
            w_flush_e = 1'b1;
          end
        end
        S_BUSY: begin
          {w_en_f, w_en_d, w_en_e} = 3'b000;
          w_flush_m = 1'b1;
        end
        S_DONE: begin
          w_done = 1'b1;
          if (hz.pcsrc_e) begin
            w_flush_d = 1'b1;
            w_flush_e = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign hz.en_f         = w_en_f;
  assign hz.en_d         = w_en_d;
  assign hz.en_e         = w_en_e;
  assign hz.en_m         = w_en_m;
  assign hz.en_w         = w_en_w;
  assign hz.flush_d      = w_flush_d;
  assign hz.flush_e      = w_flush_e;
  assign hz.flush_m      = w_flush_m;
  assign hz.muldiv_start = w_start & reset_n;
  assign hz.muldiv_done  = w_done & reset_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!w_en_f && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush_d && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign hz.stall_cnt = r_stall_cnt;
  assign hz.flush_cnt = r_flush_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Table-driven + sequence bench for hazard_ctrl with an expected-value scoreboard
// and a saturating counter model.
module tb_hazard_ctrl;
  localparam int LAT = 4;
  localparam int CW  = 5;

  localparam logic [13:0] E_DEF = 14'b11111_000_00_00_00;
  localparam logic [13:0] E_FRZ = 14'b00000_000_00_00_00;
  localparam logic [13:0] E_LU  = 14'b00111_010_00_00_00;
  localparam logic [13:0] E_BR  = 14'b11111_110_00_00_00;
  localparam logic [13:0] E_MDS = 14'b00011_001_00_00_10;
  localparam logic [13:0] E_MDB = 14'b00011_001_00_00_00;
  localparam logic [13:0] E_MDD = 14'b11111_000_00_00_01;

  typedef struct {
    string      name;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       memread_e, muldiv_e, pcsrc_e, regwrite_m, regwrite_w;
    logic       dmem_req_m, dmem_ready;
    logic [13:0] exp; // {en_f,en_d,en_e,en_m,en_w, flush_d,flush_e,flush_m, fwd_a, fwd_b, start, done}
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(CW)) hz ();
  hazard_ctrl #(.MULDIV_LAT(LAT), .CNT_W(CW)) dut (.clk(clk), .reset_n(reset_n), .hz(hz.slave));

  int total = 0;
  int bad   = 0;
  vec_t exp_q[$];
  vec_t tbl[$];
  logic [CW-1:0] m_stall = '0, m_flush = '0;

  function automatic vec_t mk(input string n, input logic [13:0] e);
    vec_t t;
    t.name = n;
    t.rs1_d = 0; t.rs2_d = 0; t.rs1_e = 0; t.rs2_e = 0; t.rd_e = 0; t.rd_m = 0; t.rd_w = 0;
    t.memread_e = 0; t.muldiv_e = 0; t.pcsrc_e = 0; t.regwrite_m = 0; t.regwrite_w = 0;
    t.dmem_req_m = 0; t.dmem_ready = 0;
    t.exp = e;
    return t;
  endfunction

  task automatic drive(input vec_t t);
    hz.rs1_d = t.rs1_d; hz.rs2_d = t.rs2_d; hz.rs1_e = t.rs1_e; hz.rs2_e = t.rs2_e;
    hz.rd_e = t.rd_e; hz.rd_m = t.rd_m; hz.rd_w = t.rd_w;
    hz.memread_e = t.memread_e; hz.muldiv_e = t.muldiv_e; hz.pcsrc_e = t.pcsrc_e;
    hz.regwrite_m = t.regwrite_m; hz.regwrite_w = t.regwrite_w;
    hz.dmem_req_m = t.dmem_req_m; hz.dmem_ready = t.dmem_ready;
    exp_q.push_back(t);
  endtask

  task automatic check();
    vec_t t;
    logic [13:0] got;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard_empty got=none exp=entry");
      return;
    end
    t = exp_q.pop_front();
    got = {hz.en_f, hz.en_d, hz.en_e, hz.en_m, hz.en_w, hz.flush_d, hz.flush_e, hz.flush_m,
           hz.fwd_a_e, hz.fwd_b_e, hz.muldiv_start, hz.muldiv_done};
    total++;
    if (got !== t.exp) begin
      bad++;
      $display("FAIL %s ctl got=%b exp=%b", t.name, got, t.exp);
    end
    total++;
    if (hz.stall_cnt !== m_stall) begin
      bad++;
      $display("FAIL %s stall_cnt got=%0d exp=%0d", t.name, hz.stall_cnt, m_stall);
    end
    total++;
    if (hz.flush_cnt !== m_flush) begin
      bad++;
      $display("FAIL %s flush_cnt got=%0d exp=%0d", t.name, hz.flush_cnt, m_flush);
    end
    if (reset_n) begin
      if (!t.exp[13] && m_stall != '1) m_stall++;
      if (t.exp[8] && m_flush != '1) m_flush++;
    end
  endtask

  task automatic step(input vec_t t);
    drive(t);
    @(negedge clk);
    check();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t t;

    // reset state
    step(mk("reset_idle", E_DEF));
    reset_n = 1'b1;

    t = mk("nop", E_DEF); tbl.push_back(t);
    t = mk("fwd_a_mem", 14'b11111_000_10_00_00); t.regwrite_m = 1; t.rd_m = 3; t.rs1_e = 3; tbl.push_back(t);
    t = mk("fwd_b_wb", 14'b11111_000_00_01_00); t.regwrite_w = 1; t.rd_w = 7; t.rs2_e = 7; tbl.push_back(t);
    t = mk("fwd_mem_prio", 14'b11111_000_10_10_00);
    t.regwrite_m = 1; t.regwrite_w = 1; t.rd_m = 4; t.rd_w = 4; t.rs1_e = 4; t.rs2_e = 4; tbl.push_back(t);
    t = mk("fwd_x0", E_DEF); t.regwrite_m = 1; t.regwrite_w = 1; tbl.push_back(t);
    t = mk("fwd_a_wb_nowr_m", 14'b11111_000_01_00_00);
    t.rd_m = 9; t.regwrite_w = 1; t.rd_w = 9; t.rs1_e = 9; tbl.push_back(t);
    t = mk("load_use_rs1", E_LU); t.memread_e = 1; t.rd_e = 5; t.rs1_d = 5; tbl.push_back(t);
    t = mk("load_x0", E_DEF); t.memread_e = 1; t.rd_e = 0; t.rs2_d = 0; tbl.push_back(t);
    t = mk("br_over_lu", E_BR); t.memread_e = 1; t.rd_e = 6; t.rs2_d = 6; t.pcsrc_e = 1; tbl.push_back(t);
    t = mk("branch", E_BR); t.pcsrc_e = 1; tbl.push_back(t);
    t = mk("freeze", E_FRZ); t.dmem_req_m = 1; tbl.push_back(t);
    t = mk("freeze_br", E_FRZ); t.dmem_req_m = 1; t.pcsrc_e = 1; tbl.push_back(t);
    t = mk("br_deferred", E_BR); t.dmem_req_m = 1; t.dmem_ready = 1; t.pcsrc_e = 1; tbl.push_back(t);
    t = mk("freeze_lu", E_FRZ); t.dmem_req_m = 1; t.memread_e = 1; t.rd_e = 2; t.rs1_d = 2; tbl.push_back(t);
    t = mk("freeze_muldiv", E_FRZ); t.dmem_req_m = 1; t.muldiv_e = 1; tbl.push_back(t);
    foreach (tbl[i]) step(tbl[i]);

    // load-use bubble then MEM forwarding
    t = mk("lu_stall", E_LU); t.memread_e = 1; t.rd_e = 5; t.rs1_d = 5; step(t);
    t = mk("lu_fwd", 14'b11111_000_10_00_00); t.regwrite_m = 1; t.rd_m = 5; t.rs1_e = 5; step(t);

    // mul/div: start, LAT busy cycles, done, idle
    t = mk("md_start", E_MDS); t.muldiv_e = 1; step(t);
    for (int i = 0; i < LAT; i++) begin
      t = mk("md_busy", E_MDB); t.muldiv_e = 1; step(t);
    end
    t = mk("md_done", E_MDD); t.muldiv_e = 1; step(t);
    step(mk("md_idle", E_DEF));

    // mul/div frozen in DONE for 3 cycles
    t = mk("mdf_start", E_MDS); t.muldiv_e = 1; step(t);
    for (int i = 0; i < LAT; i++) begin
      t = mk("mdf_busy", E_MDB); t.muldiv_e = 1; step(t);
    end
    for (int i = 0; i < 3; i++) begin
      t = mk("mdf_frozen", E_FRZ); t.muldiv_e = 1; t.dmem_req_m = 1; step(t);
    end
    t = mk("mdf_done", E_MDD); t.muldiv_e = 1; step(t);
    step(mk("mdf_idle", E_DEF));

    // reset mid-BUSY
    t = mk("mdr_start", E_MDS); t.muldiv_e = 1; step(t);
    t = mk("mdr_busy", E_MDB); t.muldiv_e = 1; step(t);
    reset_n = 1'b0;
    m_stall = '0; m_flush = '0;
    step(mk("mdr_in_reset", E_DEF));
    reset_n = 1'b1;
    for (int i = 0; i < LAT + 2; i++) step(mk("mdr_after", E_DEF));

    // stall counter saturation
    for (int i = 0; i < 40; i++) begin
      t = mk("sat_freeze", E_FRZ); t.dmem_req_m = 1; step(t);
    end
    step(mk("sat_hold", E_DEF));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the five-stage core. It drives the enable and flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and it selects the EX-stage forwarding muxes. It resolves four conditions: load-use hazards, taken branches and jumps, data-memory wait states, and a fixed-latency multi-cycle mul/div unit, which it sequences with a small FSM. It also keeps saturating stall and flush performance counters.

## Interface
Parameters:
- MULDIV_LAT, 4: cycles the mul/div unit needs after its start pulse; legal range ≥1.
- CNT_W, 32: width of each performance counter.

Ports:
- clk  in  1  core clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rs1_d, rs2_d  in  5  source registers of the instruction in ID.
- rs1_e, rs2_e  in  5  source registers of the instruction in EX.
- rd_e  in  5  destination register of the instruction in EX.
- memread_e  in  1  the instruction in EX is a load.
- muldiv_e  in  1  the instruction in EX is a mul/div.
- pcsrc_e  in  1  a branch or jump in EX is taken.
- rd_m, rd_w  in  5  destination registers of the instructions in MEM and WB.
- regwrite_m, regwrite_w  in  1  the MEM and WB instructions write the register file.
- dmem_req_m  in  1  the MEM stage has an outstanding data-memory access.
- dmem_ready  in  1  data-memory access completes this cycle.
- en_f, en_d, en_e, en_m, en_w  out  1  enables for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- flush_d, flush_e, flush_m  out  1  synchronous clears for IF/ID, ID/EX and EX/MEM; a clear overrides the matching enable.
- fwd_a_e, fwd_b_e  out  2  forwarding selects: 00 = register file, 01 = WB, 10 = MEM.
- muldiv_start  out  1  one-cycle start pulse to the mul/div unit.
- muldiv_done  out  1  the mul/div result is valid and the instruction leaves EX this cycle.
- stall_cnt, flush_cnt  out  CNT_W  performance counters.

## Operation
- All enable, flush and forward outputs are combinational from the FSM state and the current inputs.
- The FSM state, the latency counter and the performance counters are registered.
- **Forwarding.** fwd_a_e = 10 when regwrite_m, rd_m≠0 and rd_m==rs1_e. Otherwise it is 01 when regwrite_w, rd_w≠0 and rd_w==rs1_e. Otherwise it is 00. fwd_b_e follows the same rule with rs2_e.
- **Freeze.** freeze = dmem_req_m & ~dmem_ready. This is the highest priority.
  - All five enables are 0 and all flushes are 0.
  - muldiv_start is 0.
  - The FSM does not leave IDLE or DONE while frozen.
- **FSM.** States are IDLE, BUSY and DONE. The latency counter cnt is $clog2(MULDIV_LAT)+1 bits wide.
- **IDLE with muldiv_e and no freeze:**
  - muldiv_start=1.
  - en_f, en_d, en_e = 0; flush_m=1; en_m, en_w = 1.
  - cnt ← MULDIV_LAT-1; next state is BUSY.
- **BUSY:**
  - en_f, en_d, en_e = 0; flush_m=1 unless frozen.
  - cnt decrements every cycle, including frozen cycles.
  - At cnt==0 the next state is DONE.
- **DONE with no freeze:**
  - muldiv_done=1; all enables are 1.
  - The next state is IDLE.
  - If frozen, the FSM stays in DONE and muldiv_done=0.
- **Load-use hazard.** Applies only in IDLE, with no freeze and muldiv_e=0. Condition: memread_e, rd_e≠0, and rd_e==rs1_d or rd_e==rs2_d.
  - en_f, en_d = 0; flush_e=1.
- **Taken branch.** Applies in IDLE or DONE with no freeze.
  - pcsrc_e sets flush_d=1 and flush_e=1, and en_f=1.
  - This overrides the load-use stall: the stalled instruction is discarded anyway.
- **Default.** All enables are 1 and all flushes are 0.
- **stall_cnt** increments in every cycle with en_f==0, including freeze cycles.
- **flush_cnt** increments in every cycle with flush_d==1.
- Both counters saturate at all-ones and never wrap.

## Timing
- **Reset** (reset_n low) takes effect asynchronously:
  - FSM returns to IDLE, cnt is cleared to 0, and both counters are cleared to 0.
  - muldiv_start and muldiv_done are 0.
  - The remaining outputs follow the IDLE equations for the current inputs.
- **Load-use costs one bubble.** The cycle after the stall, the load is in MEM, fwd_*=10 resolves the dependency, and the dependent instruction proceeds.
- **Branch costs two squashed instructions,** issued in the cycle pcsrc_e is high.
- **A mul/div occupies EX for MULDIV_LAT+2 unfrozen cycles:** 1 IDLE cycle, then MULDIV_LAT BUSY cycles, then 1 DONE cycle. muldiv_done comes MULDIV_LAT+1 cycles after muldiv_start.
- **Reset mid-BUSY** abandons the operation. No muldiv_done is issued.
- **Simultaneous freeze and pcsrc_e:** the flush is deferred. Because EX is frozen, pcsrc_e persists and is applied on the first unfrozen cycle.
- **rd=x0** never causes a forward or a load-use stall.

## Test plan
- Load to x5 in EX, ID instruction with rs1=5 → one cycle with en_f=en_d=0 and flush_e=1. Next cycle fwd_a_e=10 with rd_m=5. stall_cnt=1.
- Load to x0 in EX, ID instruction with rs2=0 → no stall; all enables are 1.
- pcsrc_e=1 together with a load-use condition → flush_d=flush_e=1 and en_f=1. flush_cnt increments by 1.
- MULDIV_LAT=4, muldiv_e=1 → muldiv_start in cycle 0; en_e=0 for cycles 0–4; muldiv_done in cycle 5; IDLE in cycle 6. stall_cnt=5.
- dmem_req_m=1 with dmem_ready=0 for 3 cycles while in DONE → all enables 0 for 3 cycles. muldiv_done asserts on the 4th cycle. The counter stayed exhausted throughout.
- Assert reset_n=0 mid-BUSY → FSM IDLE, counters 0, muldiv_done never asserts. Also preload stall_cnt to all-ones, then stall → stall_cnt holds all-ones.
